// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU palette/VRAM access path.
package ppu_pkg;

   localparam logic [2:0]  REG_STATUS     = 3'd2;
   localparam logic [2:0]  REG_ADDR       = 3'd6;
   localparam logic [2:0]  REG_DATA       = 3'd7;

   localparam logic [5:0]  PAL_PAGE       = 6'h3F;
   localparam logic [13:0] NT_MIRROR_MASK = 14'h2FFF;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
      logic       rw;
   } pal_req_t;

   typedef enum logic [1:0] {
      PORT_IDLE,
      PORT_RENDER,
      PORT_FLUSH,
      PORT_CPU
   } pal_owner_t;

endpackage

// File: rtl/ppu_pal_arbiter.sv
// Palette port arbiter: render > pending flush > CPU, with a single-entry
// deferred-write register for CPU writes that lose arbitration.
module ppu_pal_arbiter
   import ppu_pkg::*;
#(
   parameter int PAL_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_render,
   input  logic [PAL_AW-1:0] i_render_addr,
   input  logic              i_cpu_valid,
   input  logic              i_cpu_rw,
   input  logic [PAL_AW-1:0] i_cpu_addr,
   input  logic [7:0]        i_cpu_data,
   output logic              o_render_gnt,
   output logic              o_cpu_gnt,
   output logic [PAL_AW-1:0] o_pal_addr,
   output logic [7:0]        o_pal_wdata,
   output logic              o_pal_rw,
   output logic              o_pal_en,
   output logic              o_pend_busy
);

   pal_req_t   r_pend;
   logic       r_pend_vld;
   pal_req_t   w_cpu_req;
   pal_owner_t w_owner;
   logic       w_defer;

   assign w_cpu_req = '{addr: i_cpu_addr, data: i_cpu_data, rw: i_cpu_rw};

   always_comb begin
      w_owner = PORT_IDLE;
      if (i_render)         w_owner = PORT_RENDER;
      else if (r_pend_vld)  w_owner = PORT_FLUSH;
      else if (i_cpu_valid) w_owner = PORT_CPU;
   end

   // A CPU write that does not own the port replaces whatever is pending.
   assign w_defer = i_cpu_valid && i_cpu_rw && (w_owner != PORT_CPU);

   always_comb begin
      o_pal_en    = 1'b0;
      o_pal_rw    = 1'b0;
      o_pal_addr  = '0;
      o_pal_wdata = '0;
      case (w_owner)
         PORT_RENDER: begin
            o_pal_en   = 1'b1;
            o_pal_addr = i_render_addr;
         end
         PORT_FLUSH: begin
            o_pal_en    = 1'b1;
            o_pal_rw    = r_pend.rw;
            o_pal_addr  = r_pend.addr;
            o_pal_wdata = r_pend.data;
         end
         PORT_CPU: begin
            o_pal_en    = 1'b1;
            o_pal_rw    = i_cpu_rw;
            o_pal_addr  = i_cpu_addr;
            o_pal_wdata = i_cpu_rw ? i_cpu_data : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
      end else if (w_defer) begin
         r_pend     <= w_cpu_req;
         r_pend_vld <= 1'b1;
      end else if (w_owner == PORT_FLUSH) begin
         r_pend_vld <= 1'b0;
      end
   end

   assign o_render_gnt = (w_owner == PORT_RENDER);
   assign o_cpu_gnt    = (w_owner == PORT_CPU);
   assign o_pend_busy  = r_pend_vld;

endmodule

// File: rtl/ppu_palette_access_ctrl.sv
// CPU-side PPUADDR/PPUDATA/PPUSTATUS decode, VRAM address/toggle/read buffer,
// and the palette memory port shared with the pixel pipeline.
module ppu_palette_access_ctrl
   import ppu_pkg::*;
#(
   parameter int VRAM_AW = 14,
   parameter int PAL_AW  = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         reg_sel,
   input  logic               reg_wr,
   input  logic               reg_rd,
   input  logic [7:0]         cpu_data_in,
   output logic [7:0]         cpu_data_out,
   input  logic               inc32,
   input  logic               render_active,
   input  logic               render_req,
   input  logic [PAL_AW-1:0]  render_pal_addr,
   output logic [5:0]         pixel_color,
   output logic               pixel_valid,
   output logic [PAL_AW-1:0]  pal_addr,
   output logic [7:0]         palette_data_in,
   output logic               palette_mem_rw,
   output logic               palette_mem_en,
   input  logic [7:0]         color_out,
   output logic [VRAM_AW-1:0] vram_addr,
   output logic               vram_wr,
   output logic               vram_rd,
   output logic [7:0]         vram_wdata,
   input  logic [7:0]         vram_rdata,
   output logic               pend_busy
);

   localparam logic [VRAM_AW-1:0] INC_1  = VRAM_AW'(1);
   localparam logic [VRAM_AW-1:0] INC_32 = VRAM_AW'(32);

   logic [VRAM_AW-1:0] r_v;
   logic [5:0]         r_t_hi;
   logic               r_w;
   logic [7:0]         r_rd_buf;
   logic               r_fill_pend;

   logic w_rd_ok, w_status_rd, w_addr_wr, w_data_wr, w_data_rd, w_data_acc;
   logic w_in_pal, w_render_gnt, w_cpu_gnt, w_unused;
   logic [VRAM_AW-1:0] w_v_inc;

   assign w_rd_ok     = reg_rd && !reg_wr;
   assign w_status_rd = w_rd_ok && (reg_sel == REG_STATUS);
   assign w_addr_wr   = reg_wr  && (reg_sel == REG_ADDR);
   assign w_data_wr   = reg_wr  && (reg_sel == REG_DATA);
   assign w_data_rd   = w_rd_ok && (reg_sel == REG_DATA);
   assign w_data_acc  = w_data_wr || w_data_rd;
   assign w_in_pal    = (r_v[13:8] == PAL_PAGE);
   assign w_v_inc     = r_v + (inc32 ? INC_32 : INC_1);
   assign w_unused    = &{1'b0, color_out[7:6]};

   ppu_pal_arbiter #(.PAL_AW(PAL_AW)) u_arb (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_render     (render_active && render_req),
      .i_render_addr(render_pal_addr),
      .i_cpu_valid  (w_data_acc && w_in_pal),
      .i_cpu_rw     (w_data_wr),
      .i_cpu_addr   (r_v[4:0]),
      .i_cpu_data   (cpu_data_in),
      .o_render_gnt (w_render_gnt),
      .o_cpu_gnt    (w_cpu_gnt),
      .o_pal_addr   (pal_addr),
      .o_pal_wdata  (palette_data_in),
      .o_pal_rw     (palette_mem_rw),
      .o_pal_en     (palette_mem_en),
      .o_pend_busy  (pend_busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v          <= '0;
         r_t_hi       <= '0;
         r_w          <= 1'b0;
         r_rd_buf     <= '0;
         r_fill_pend  <= 1'b0;
         cpu_data_out <= '0;
         pixel_color  <= '0;
         pixel_valid  <= 1'b0;
         vram_addr    <= '0;
         vram_wr      <= 1'b0;
         vram_rd      <= 1'b0;
         vram_wdata   <= '0;
      end else begin
         vram_wr     <= 1'b0;
         vram_rd     <= 1'b0;
         pixel_valid <= w_render_gnt;
         // vram_rdata arrives the cycle after the vram_rd pulse.
         r_fill_pend <= vram_rd;
         if (r_fill_pend) r_rd_buf <= vram_rdata;
         if (w_render_gnt) pixel_color <= color_out[5:0];

         if (w_status_rd) r_w <= 1'b0;
         if (w_addr_wr) begin
            if (!r_w) begin
               r_t_hi <= cpu_data_in[5:0];
               r_w    <= 1'b1;
            end else begin
               r_v <= {r_t_hi, cpu_data_in};
               r_w <= 1'b0;
            end
         end

         if (w_data_acc) r_v <= w_v_inc;

         if (w_data_wr && !w_in_pal) begin
            vram_wr    <= 1'b1;
            vram_addr  <= r_v;
            vram_wdata <= cpu_data_in;
         end

         if (w_data_rd) begin
            vram_rd <= 1'b1;
            if (w_in_pal) begin
               vram_addr    <= r_v & NT_MIRROR_MASK;
               cpu_data_out <= w_cpu_gnt ? {2'b00, color_out[5:0]} : '0;
            end else begin
               vram_addr    <= r_v;
               cpu_data_out <= r_rd_buf;
            end
         end
      end
   end

endmodule
